code_memory_loader: RTL and testbench

Sequencer that copies one 16-word user-code bank (low or high image) from the user-code ROMs into the i281 writable instruction memory. While it copies, it stalls the CPU. When the copy is finished it pulses a PC clear so the CPU restarts at address 0. It sits between the user-code ROM mux, the instruction-memory write port and the CPU control unit.

---
 rtl/code_memory_loader.sv | 169 ++++++++++++++++
 tb/tb_code_memory_loader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_memory_loader.sv
// code_memory_loader
// Copies one user-code bank from the user-code ROM mux into the writable
// instruction memory. The CPU is held for the whole copy, and the PC is
// cleared when the copy finishes so execution restarts at address 0.
module code_memory_loader #(
   parameter int unsigned WORDS    = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned HOLD_CYC = 2,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_req,
   input  logic              i_bank_sel,
   input  logic              i_abort,
   output logic              o_rom_bank,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_cpu_hold,
   output logic              o_pc_clear,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_valid,
   output logic              o_loaded_bank
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HOLD   = 3'd1;
   localparam logic [2:0] S_READ   = 3'd2;
   localparam logic [2:0] S_WRITE  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   // Last value of the shared wait counter in HOLD and READ respectively.
   localparam logic [2:0]        HOLD_LAST = 3'(HOLD_CYC - 1);
   localparam logic [2:0]        RD_LAST   = 3'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(WORDS - 1);

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [2:0]        r_wait;
   logic [DATA_W-1:0] r_data;
   logic              r_bank;
   logic              r_valid;
   logic              r_loaded_bank;

   logic [2:0]        w_state_nxt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic [2:0]        w_wait_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_bank_nxt;
   logic              w_valid_nxt;
   logic              w_loaded_bank_nxt;
   logic              w_finish;

   // Next-state logic for the copy sequencer and its bookkeeping registers.
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_wait_nxt        = r_wait;
      w_data_nxt        = r_data;
      w_bank_nxt        = r_bank;
      w_valid_nxt       = r_valid;
      w_loaded_bank_nxt = r_loaded_bank;

      case (r_state)
         S_IDLE: begin
            // abort beats a simultaneous load_req
            if (i_load_req && !i_abort) begin
               w_state_nxt = S_HOLD;
               w_bank_nxt  = i_bank_sel;
               w_cnt_nxt   = '0;
               w_wait_nxt  = '0;
               // memory is partial from the first write onwards
               w_valid_nxt = 1'b0;
            end
         end

         S_HOLD: begin
            if (r_wait == HOLD_LAST) begin
               w_state_nxt = S_READ;
               w_wait_nxt  = '0;
            end else begin
               w_wait_nxt = r_wait + 3'd1;
            end
         end

         S_READ: begin
            if (r_wait == RD_LAST) begin
               // ROM output has settled for the current address
               w_data_nxt  = i_rom_data;
               w_state_nxt = S_WRITE;
               w_wait_nxt  = '0;
            end else begin
               w_wait_nxt = r_wait + 3'd1;
            end
         end

         S_WRITE: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_FINISH;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
               w_state_nxt = S_READ;
            end
         end

         S_FINISH: begin
            w_state_nxt       = S_IDLE;
            w_valid_nxt       = 1'b1;
            w_loaded_bank_nxt = r_bank;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Abort from any active state, including FINISH, discards the copy.
      if ((r_state != S_IDLE) && i_abort) begin
         w_state_nxt       = S_IDLE;
         w_wait_nxt        = '0;
         w_valid_nxt       = 1'b0;
         w_loaded_bank_nxt = r_loaded_bank;
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_wait        <= '0;
         r_data        <= '0;
         r_bank        <= 1'b0;
         r_valid       <= 1'b0;
         r_loaded_bank <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_wait        <= w_wait_nxt;
         r_data        <= w_data_nxt;
         r_bank        <= w_bank_nxt;
         r_valid       <= w_valid_nxt;
         r_loaded_bank <= w_loaded_bank_nxt;
      end
   end

   assign w_finish = (r_state == S_FINISH);

   // Outputs come straight from registers or the state decode; only the
   // completion pulse is gated by abort so an aborted FINISH never reports.
   assign o_rom_bank    = r_bank;
   assign o_rom_addr    = r_cnt;
   assign o_mem_we      = (r_state == S_WRITE);
   assign o_mem_waddr   = r_cnt;
   assign o_mem_wdata   = r_data;
   assign o_busy        = (r_state != S_IDLE);
   assign o_cpu_hold    = (r_state != S_IDLE);
   assign o_done        = w_finish & ~i_abort;
   assign o_pc_clear    = w_finish & ~i_abort;
   assign o_valid       = r_valid;
   assign o_loaded_bank = r_loaded_bank;

endmodule

// File: tb/tb_code_memory_loader.sv
// Directed bench for code_memory_loader: full loads, slow ROM, abort,
// ignored inputs, asynchronous reset and abort/start collision.
module tb_code_memory_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_req, bank_sel, abort;
   logic        rom_bank;
   logic [3:0]  rom_addr;
   logic [15:0] rom_data;
   logic        mem_we;
   logic [3:0]  mem_waddr;
   logic [15:0] mem_wdata;
   logic        cpu_hold, pc_clear, busy, done, valid, loaded_bank;

   logic        load_req3, bank_sel3, abort3;
   logic        rom_bank3;
   logic [3:0]  rom_addr3;
   logic [15:0] rom_data3;
   logic        mem_we3;
   logic [3:0]  mem_waddr3;
   logic [15:0] mem_wdata3;
   logic        cpu_hold3, pc_clear3, busy3, done3, valid3, loaded_bank3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Hand-written ROM images.
   function automatic logic [15:0] rom_word(input logic b, input logic [3:0] a);
      if (b) begin
         case (a)
            4'd0:    return 16'h5401;
            4'd1:    return 16'hE0F6;
            4'd8:    return 16'hE0E8;
            default: return (a >= 4'd9) ? 16'h0000 : {12'h330, a};
         endcase
      end else begin
         return {a, 4'h0, ~a, a};
      end
   endfunction

   // RD_LAT=1: data reflects the address during the same (only) READ cycle.
   assign rom_data = rom_word(rom_bank, rom_addr);

   // RD_LAT=3: two pipeline stages, so data is only right on the 3rd cycle.
   logic [3:0] a1, a2;
   logic       b1, b2;
   always @(posedge clk) begin
      a1 <= rom_addr3;
      a2 <= a1;
      b1 <= rom_bank3;
      b2 <= b1;
   end
   assign rom_data3 = rom_word(b2, a2);

   code_memory_loader #(.WORDS(16), .ADDR_W(4), .DATA_W(16), .HOLD_CYC(2), .RD_LAT(1)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_load_req(load_req), .i_bank_sel(bank_sel),
      .i_abort(abort), .o_rom_bank(rom_bank), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
      .o_mem_we(mem_we), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
      .o_cpu_hold(cpu_hold), .o_pc_clear(pc_clear), .o_busy(busy), .o_done(done),
      .o_valid(valid), .o_loaded_bank(loaded_bank)
   );

   code_memory_loader #(.WORDS(16), .ADDR_W(4), .DATA_W(16), .HOLD_CYC(2), .RD_LAT(3)) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_load_req(load_req3), .i_bank_sel(bank_sel3),
      .i_abort(abort3), .o_rom_bank(rom_bank3), .o_rom_addr(rom_addr3),
      .i_rom_data(rom_data3), .o_mem_we(mem_we3), .o_mem_waddr(mem_waddr3),
      .o_mem_wdata(mem_wdata3), .o_cpu_hold(cpu_hold3), .o_pc_clear(pc_clear3),
      .o_busy(busy3), .o_done(done3), .o_valid(valid3), .o_loaded_bank(loaded_bank3)
   );

   // Recorders: cycle numbers are relative to the accept edge (cycle 1 follows it).
   int e0 = 0, e03 = 0;
   int n_wr = 0, n_done = 0, n_pc = 0, done_cyc = 0, pc_cyc = 0, busy_last = 0;
   logic [3:0]  wr_addr [0:255];
   logic [15:0] wr_data [0:255];
   int          wr_cyc  [0:255];
   int n_wr3 = 0, n_done3 = 0, done_cyc3 = 0;
   logic [3:0]  wr_addr3 [0:63];
   logic [15:0] wr_data3 [0:63];
   int          wr_cyc3  [0:63];

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (n_wr < 256) begin
            wr_addr[n_wr] = mem_waddr;
            wr_data[n_wr] = mem_wdata;
            wr_cyc[n_wr]  = cyc - e0 + 1;
         end
         n_wr++;
      end
      if (done === 1'b1) begin
         n_done++;
         done_cyc = cyc - e0 + 1;
      end
      if (pc_clear === 1'b1) begin
         n_pc++;
         pc_cyc = cyc - e0 + 1;
      end
      if (busy === 1'b1) busy_last = cyc - e0 + 1;
      if (mem_we3 === 1'b1) begin
         if (n_wr3 < 64) begin
            wr_addr3[n_wr3] = mem_waddr3;
            wr_data3[n_wr3] = mem_wdata3;
            wr_cyc3[n_wr3]  = cyc - e03 + 1;
         end
         n_wr3++;
      end
      if (done3 === 1'b1) begin
         n_done3++;
         done_cyc3 = cyc - e03 + 1;
      end
   end

   task automatic test_reset();
      logic [31:0] snap, snap3;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      snap  = {rom_bank, rom_addr, mem_we, mem_waddr, mem_wdata, cpu_hold, pc_clear, busy,
               done, valid, loaded_bank};
      snap3 = {rom_bank3, rom_addr3, mem_we3, mem_waddr3, mem_wdata3, cpu_hold3, pc_clear3,
               busy3, done3, valid3, loaded_bank3};
      checks++;
      if (snap !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h want %h", snap, 32'h0);
      end
      checks++;
      if (snap3 !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs_rdlat3 got %h want %h", snap3, 32'h0);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_high();
      int wb, db, pb;
      wb = n_wr; db = n_done; pb = n_pc;
      @(negedge clk);
      bank_sel = 1'b1; load_req = 1'b1;
      @(posedge clk); #1;
      e0 = cyc; load_req = 1'b0; bank_sel = 1'b0;
      checks++;
      if ({busy, cpu_hold, rom_bank} !== 3'b111) begin
         errors++;
         $display("FAIL accept_busy_hold_bank got %b want 111", {busy, cpu_hold, rom_bank});
      end
      repeat (40) @(negedge clk);
      checks++;
      if (n_wr - wb !== 16) begin
         errors++;
         $display("FAIL full_write_count got %0d want 16", n_wr - wb);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (wr_addr[wb+k] !== k[3:0] || wr_data[wb+k] !== rom_word(1'b1, k[3:0]) ||
             wr_cyc[wb+k] !== 2 + 2*k + 2) begin
            errors++;
            $display("FAIL full_write_%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", k,
                     wr_addr[wb+k], wr_data[wb+k], wr_cyc[wb+k], k, rom_word(1'b1, k[3:0]),
                     2 + 2*k + 2);
         end
      end
      checks++;
      if (n_done - db !== 1 || done_cyc !== 35) begin
         errors++;
         $display("FAIL full_done got n=%0d cyc=%0d want n=1 cyc=35", n_done - db, done_cyc);
      end
      checks++;
      if (n_pc - pb !== 1 || pc_cyc !== 35) begin
         errors++;
         $display("FAIL full_pc_clear got n=%0d cyc=%0d want n=1 cyc=35", n_pc - pb, pc_cyc);
      end
      checks++;
      if (busy_last !== 35) begin
         errors++;
         $display("FAIL full_busy_last_cycle got %0d want 35", busy_last);
      end
      checks++;
      if ({valid, loaded_bank, busy, cpu_hold} !== 4'b1100) begin
         errors++;
         $display("FAIL full_final_flags got %b want 1100",
                  {valid, loaded_bank, busy, cpu_hold});
      end
   endtask

   task automatic test_rdlat3_low();
      int wb, db;
      wb = n_wr3; db = n_done3;
      @(negedge clk);
      bank_sel3 = 1'b0; load_req3 = 1'b1;
      @(posedge clk); #1;
      e03 = cyc; load_req3 = 1'b0;
      repeat (75) @(negedge clk);
      checks++;
      if (n_wr3 - wb !== 16) begin
         errors++;
         $display("FAIL rdlat3_write_count got %0d want 16", n_wr3 - wb);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (wr_addr3[wb+k] !== k[3:0] || wr_data3[wb+k] !== rom_word(1'b0, k[3:0]) ||
             wr_cyc3[wb+k] !== 2 + 4*k + 4) begin
            errors++;
            $display("FAIL rdlat3_write_%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", k,
                     wr_addr3[wb+k], wr_data3[wb+k], wr_cyc3[wb+k], k, rom_word(1'b0, k[3:0]),
                     2 + 4*k + 4);
         end
      end
      checks++;
      if (n_done3 - db !== 1 || done_cyc3 !== 67) begin
         errors++;
         $display("FAIL rdlat3_done got n=%0d cyc=%0d want n=1 cyc=67", n_done3 - db,
                  done_cyc3);
      end
      checks++;
      if ({valid3, loaded_bank3, busy3} !== 3'b100) begin
         errors++;
         $display("FAIL rdlat3_final_flags got %b want 100", {valid3, loaded_bank3, busy3});
      end
   endtask

   task automatic test_abort_word5();
      int wb, db, pb;
      wb = n_wr; db = n_done; pb = n_pc;
      @(negedge clk);
      bank_sel = 1'b0; load_req = 1'b1;
      @(posedge clk); #1;
      e0 = cyc; load_req = 1'b0;
      // READ of word 5 is cycle 13
      repeat (13) @(negedge clk);
      checks++;
      if (rom_addr !== 4'd5 || mem_we !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_read5 got addr=%0d we=%b busy=%b want addr=5 we=0 busy=1",
                  rom_addr, mem_we, busy);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if ({busy, cpu_hold, valid, loaded_bank, done, pc_clear} !== 6'b000100) begin
         errors++;
         $display("FAIL abort_next_edge got %b want 000100",
                  {busy, cpu_hold, valid, loaded_bank, done, pc_clear});
      end
      repeat (40) @(negedge clk);
      checks++;
      if (n_wr - wb !== 5 || wr_addr[wb+4] !== 4'd4) begin
         errors++;
         $display("FAIL abort_writes got n=%0d last=%0d want n=5 last=4", n_wr - wb,
                  wr_addr[wb+4]);
      end
      checks++;
      if (n_done - db !== 0 || n_pc - pb !== 0) begin
         errors++;
         $display("FAIL abort_no_done got done=%0d pc=%0d want 0 0", n_done - db, n_pc - pb);
      end
   endtask

   task automatic test_ignored_inputs();
      int wb, db, bad, badd;
      wb = n_wr; db = n_done; bad = 0; badd = 0;
      @(negedge clk);
      bank_sel = 1'b0; load_req = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         load_req = k[0];
         bank_sel = ~k[0];
         if (rom_bank !== 1'b0) bad++;
      end
      @(negedge clk);
      load_req = 1'b0; bank_sel = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL busy_rom_bank_constant got %0d bad cycles want 0", bad);
      end
      checks++;
      if (n_wr - wb !== 16) begin
         errors++;
         $display("FAIL busy_write_count got %0d want 16", n_wr - wb);
      end
      for (int k = 0; k < 16; k++)
         if (wr_data[wb+k] !== rom_word(1'b0, k[3:0]) || wr_addr[wb+k] !== k[3:0]) badd++;
      checks++;
      if (badd !== 0) begin
         errors++;
         $display("FAIL busy_write_data got %0d bad words want 0", badd);
      end
      checks++;
      if (n_done - db !== 1 || done_cyc !== 35) begin
         errors++;
         $display("FAIL busy_single_done got n=%0d cyc=%0d want n=1 cyc=35", n_done - db,
                  done_cyc);
      end
      checks++;
      if ({busy, valid, loaded_bank} !== 3'b010) begin
         errors++;
         $display("FAIL busy_final_flags got %b want 010", {busy, valid, loaded_bank});
      end
   endtask

   task automatic test_async_reset();
      int wb, db;
      logic [31:0] snap;
      wb = n_wr;
      @(negedge clk);
      bank_sel = 1'b1; load_req = 1'b1;
      @(posedge clk); #1;
      e0 = cyc; load_req = 1'b0;
      // READ of word 9 is cycle 21
      repeat (21) @(negedge clk);
      checks++;
      if (rom_addr !== 4'd9 || busy !== 1'b1) begin
         errors++;
         $display("FAIL areset_at_word9 got addr=%0d busy=%b want 9 1", rom_addr, busy);
      end
      #2 rst = 1'b1;
      #1;
      snap = {rom_bank, rom_addr, mem_we, mem_waddr, mem_wdata, cpu_hold, pc_clear, busy,
              done, valid, loaded_bank};
      checks++;
      if (snap !== 32'h0) begin
         errors++;
         $display("FAIL areset_immediate got %h want %h", snap, 32'h0);
      end
      checks++;
      if (n_wr - wb !== 9) begin
         errors++;
         $display("FAIL areset_writes_before got %0d want 9", n_wr - wb);
      end
      load_req = 1'b1; bank_sel = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wb = n_wr; db = n_done;
      @(posedge clk); #1;
      e0 = cyc; load_req = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL areset_restart_first_edge got busy=%b want 1", busy);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (n_wr - wb !== 16 || n_done - db !== 1 || done_cyc !== 35) begin
         errors++;
         $display("FAIL areset_reload got wr=%0d done=%0d cyc=%0d want 16 1 35", n_wr - wb,
                  n_done - db, done_cyc);
      end
      checks++;
      if ({valid, loaded_bank, busy} !== 3'b110) begin
         errors++;
         $display("FAIL areset_reload_flags got %b want 110", {valid, loaded_bank, busy});
      end
   endtask

   task automatic test_abort_and_load();
      int wb, seen;
      wb = n_wr; seen = 0;
      @(negedge clk);
      load_req = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL collide_no_start got busy=%b want 0", busy);
      end
      load_req = 1'b0; abort = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (busy !== 1'b0 || mem_we !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0 || n_wr - wb !== 0) begin
         errors++;
         $display("FAIL collide_quiet got active=%0d writes=%0d want 0 0", seen, n_wr - wb);
      end
      checks++;
      if (valid !== 1'b1) begin
         errors++;
         $display("FAIL collide_valid_kept got %b want 1", valid);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      load_req = 1'b0; bank_sel = 1'b0; abort = 1'b0;
      load_req3 = 1'b0; bank_sel3 = 1'b0; abort3 = 1'b0;
      test_reset();
      test_full_high();
      test_rdlat3_low();
      test_abort_word5();
      test_ignored_inputs();
      test_async_reset();
      test_abort_and_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
